// File: rtl/risc_cpu_pkg.sv
// rtl/risc_cpu_pkg.sv - shared types, field positions and default program for the 16-bit RISC CPU
package risc_cpu_pkg;

  localparam int XLEN      = 16;
  localparam int NREG      = 8;
  localparam int PC_W      = 8;
  localparam int ROM_DEPTH = 256;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS_MSB = 8;
  localparam int RS_LSB = 6;
  localparam int RT_MSB = 5;
  localparam int RT_LSB = 3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_JMP  = 4'hB,
    OP_MUL  = 4'hC,
    OP_HALT = 4'hF
  } opcode_e;

  typedef logic [XLEN-1:0] word_t;
  typedef word_t rom_t [ROM_DEPTH];

  // Sum 1..10 into R1, store it to mem[0], halt. Unused words are NOP.
  function automatic rom_t default_rom();
    rom_t r;
    for (int i = 0; i < ROM_DEPTH; i++) r[i] = '0;
    r[0] = 16'h7200;  // LDI  R1, 0
    r[1] = 16'h740A;  // LDI  R2, 10
    r[2] = 16'h1250;  // ADD  R1, R1, R2
    r[3] = 16'h64BF;  // ADDI R2, R2, -1
    r[4] = 16'hA401;  // BEQ  R2, R0, +1
    r[5] = 16'hB002;  // JMP  2
    r[6] = 16'h9200;  // ST   R1 -> mem[R0+0]
    r[7] = 16'hF000;  // HALT
    return r;
  endfunction

endpackage

// File: rtl/risc_cpu_alu.sv
// rtl/risc_cpu_alu.sv - combinational ALU and branch comparator
// Opcode C multiplies only when CPU_MUL_EN is defined.
module risc_cpu_alu
  import risc_cpu_pkg::*;
(
  input  opcode_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  y,
  output logic             eq
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADDI: y = a + imm;
`ifdef CPU_MUL_EN
      OP_MUL:  y = a * b;
`endif
      default: y = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/risc_cpu_top.sv
// rtl/risc_cpu_top.sv - single-cycle 16-bit RISC CPU: PC, ROM, register file, data RAM, halt
// Optional multiply on opcode C is enabled by defining CPU_MUL_EN.
module risc_cpu_top
  import risc_cpu_pkg::*;
#(
  parameter string PROG_FILE  = "",
  parameter int    DMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  Result
);

  localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  rom_t  rom = default_rom();
  word_t dmem [DMEM_DEPTH];

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               halt_q, halt_d;
  logic               halt;
  word_t              regs_q [NREG];
  word_t              regs_d [NREG];

  word_t              instr;
  opcode_e            op;
  logic [2:0]         rd, rs, rt;
  word_t              imm6_sx, imm9_sx;
  word_t              rd_val, rs_val, rt_val;
  word_t              alu_b, alu_y, wb_data;
  logic               alu_eq;
  logic [7:0]         ea;
  logic [DMEM_AW-1:0] dmem_addr;
  logic               reg_we, mem_we;

  assign instr   = rom[pc_q];
  assign op      = opcode_e'(instr[OP_MSB:OP_LSB]);
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rs      = instr[RS_MSB:RS_LSB];
  assign rt      = instr[RT_MSB:RT_LSB];
  assign imm6_sx = {{(XLEN-6){instr[5]}}, instr[5:0]};
  assign imm9_sx = {{(XLEN-9){instr[8]}}, instr[8:0]};

  assign rd_val  = (rd == 3'd0) ? '0 : regs_q[rd];
  assign rs_val  = (rs == 3'd0) ? '0 : regs_q[rs];
  assign rt_val  = (rt == 3'd0) ? '0 : regs_q[rt];

  // BEQ compares rd against rs, so the comparator's second operand switches to rd.
  assign alu_b   = (op == OP_BEQ) ? rd_val : rt_val;

  risc_cpu_alu u_alu (
    .op  (op),
    .a   (rs_val),
    .b   (alu_b),
    .imm (imm6_sx),
    .y   (alu_y),
    .eq  (alu_eq)
  );

  assign ea        = rs_val[7:0] + imm6_sx[7:0];
  assign dmem_addr = ea[DMEM_AW-1:0];
  assign halt      = halt_q;
  assign Result    = regs_q[1];

  always_comb begin
    pc_d    = pc_q + 8'd1;
    halt_d  = halt_q;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_data = alu_y;
    if (halt_q) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: reg_we = 1'b1;
`ifdef CPU_MUL_EN
        OP_MUL:  reg_we = 1'b1;
`endif
        OP_LDI: begin
          reg_we  = 1'b1;
          wb_data = imm9_sx;
        end
        OP_LD: begin
          reg_we  = 1'b1;
          wb_data = dmem[dmem_addr];
        end
        OP_ST:   mem_we = 1'b1;
        OP_BEQ:  if (alu_eq) pc_d = pc_q + 8'd1 + imm6_sx[7:0];
        OP_JMP:  pc_d = instr[7:0];
        OP_HALT: begin
          pc_d   = pc_q;
          halt_d = 1'b1;
        end
        default: ;
      endcase
      if (rd == 3'd0) reg_we = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_we) regs_d[rd] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      regs_q <= regs_d;
    end
  end

  // Data RAM survives reset; a store still requires the CPU to be out of reset.
  always_ff @(posedge clk) begin
    if (reset && mem_we) dmem[dmem_addr] <= rd_val;
  end

endmodule

// File: tb/tb_risc_cpu_top.sv
// tb/tb_risc_cpu_top.sv - directed self-checking bench for risc_cpu_top
module tb_risc_cpu_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] result;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  risc_cpu_top dut (
    .clk    (clk),
    .reset  (reset),
    .Result (result)
  );

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cycles, output bit done);
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (dut.halt === 1'b1) done = 1'b1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.rom[i] = 16'hF000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (result !== 16'h0000) begin
      bad++;
      $display("FAIL reset_result got=%h want=0000", result);
    end
    total++;
    if (dut.halt !== 1'b0) begin
      bad++;
      $display("FAIL reset_halt got=%b want=0", dut.halt);
    end
    total++;
    if (dut.pc_q !== 8'h00) begin
      bad++;
      $display("FAIL reset_pc got=%h want=00", dut.pc_q);
    end
  endtask

  task automatic test_default_prog();
    int cyc;
    bit done;
    apply_reset();
    run_to_halt(60, cyc, done);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL default_halt_timeout got=%0d cycles want=halt within 60", cyc);
    end
    total++;
    if (result !== 16'd55) begin
      bad++;
      $display("FAIL default_result got=%h want=0037", result);
    end
    total++;
    if (dut.dmem[0] !== 16'd55) begin
      bad++;
      $display("FAIL default_mem0 got=%h want=0037", dut.dmem[0]);
    end
  endtask

  task automatic test_halt_freeze();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (dut.pc_q !== 8'd7 || result !== 16'd55 || dut.halt !== 1'b1) begin
        bad++;
        $display("FAIL halt_freeze cyc=%0d got pc=%h res=%h halt=%b want pc=07 res=0037 halt=1",
                 i, dut.pc_q, result, dut.halt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit done;
    apply_reset();
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (result !== 16'h0000 || dut.halt !== 1'b0) begin
      bad++;
      $display("FAIL midrun_async got res=%h halt=%b want res=0000 halt=0", result, dut.halt);
    end
    repeat (2) @(negedge clk);
    total++;
    if (result !== 16'h0000 || dut.pc_q !== 8'd0) begin
      bad++;
      $display("FAIL midrun_held got res=%h pc=%h want res=0000 pc=00", result, dut.pc_q);
    end
    total++;
    if (dut.dmem[0] !== 16'd55) begin
      bad++;
      $display("FAIL midrun_ram_kept got=%h want=0037", dut.dmem[0]);
    end
    reset = 1'b1;
    run_to_halt(60, cyc, done);
    total++;
    if (!done || result !== 16'd55) begin
      bad++;
      $display("FAIL midrun_rerun got done=%b res=%h want done=1 res=0037", done, result);
    end
  endtask

  task automatic test_alu();
    logic [15:0] ops  [3] = '{16'h1298, 16'h2298, 16'h5298};
    logic [15:0] want [3] = '{16'h0004, 16'h000A, 16'hFFFA};
    int cyc;
    bit done;
    for (int k = 0; k < 3; k++) begin
      reset = 1'b0;
      clear_rom();
      dut.rom[0] = 16'h7407;  // LDI R2, 7
      dut.rom[1] = 16'h77FD;  // LDI R3, -3
      dut.rom[2] = ops[k];    // op R1, R2, R3
      apply_reset();
      run_to_halt(20, cyc, done);
      total++;
      if (!done || result !== want[k]) begin
        bad++;
        $display("FAIL alu_op%0d got done=%b res=%h want done=1 res=%h", k, done, result, want[k]);
      end
      total++;
      if (dut.pc_q !== 8'd3) begin
        bad++;
        $display("FAIL alu_halt_pc%0d got=%h want=03", k, dut.pc_q);
      end
    end
  endtask

  task automatic test_r0_mem();
    int cyc;
    bit done;
    reset = 1'b0;
    clear_rom();
    dut.rom[0] = 16'h6005;  // ADDI R0, R0, 5
    dut.rom[1] = 16'h6201;  // ADDI R1, R0, 1
    dut.rom[2] = 16'h9204;  // ST R1 -> mem[4]
    dut.rom[3] = 16'h7200;  // LDI R1, 0
    dut.rom[4] = 16'h8204;  // LD R1 <- mem[4]
    apply_reset();
    run_to_halt(20, cyc, done);
    total++;
    if (!done || result !== 16'h0001) begin
      bad++;
      $display("FAIL r0_mem_result got done=%b res=%h want done=1 res=0001", done, result);
    end
    total++;
    if (dut.dmem[4] !== 16'h0001) begin
      bad++;
      $display("FAIL r0_mem_store got=%h want=0001", dut.dmem[4]);
    end
  endtask

  task automatic test_mul();
    int cyc;
    bit done;
    logic [15:0] exp;
`ifdef CPU_MUL_EN
    exp = 16'h5F90;
`else
    exp = 16'h0000;
`endif
    reset = 1'b0;
    clear_rom();
    dut.rom[0] = 16'h7496;  // LDI R2, 150
    dut.rom[1] = 16'h1490;  // ADD R2, R2, R2 -> 300
    dut.rom[2] = 16'h1680;  // ADD R3, R2, R0
    dut.rom[3] = 16'hC298;  // MUL R1, R2, R3
    apply_reset();
    run_to_halt(20, cyc, done);
    total++;
    if (!done || result !== exp) begin
      bad++;
      $display("FAIL mul got done=%b res=%h want done=1 res=%h", done, result, exp);
    end
    total++;
    if (dut.pc_q !== 8'd4) begin
      bad++;
      $display("FAIL mul_halt_pc got=%h want=04", dut.pc_q);
    end
  endtask

  initial begin
    test_reset();
    test_default_prog();
    test_halt_freeze();
    test_reset_midrun();
    test_alu();
    test_r0_mem();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
